// File: rtl/lz77_stream_encoder.sv
// lz77_stream_encoder
// Streaming LZ77 encoder. Characters arrive one per accepted beat. Each
// token (offset, match_len, char_nxt) is emitted over a valid/ready output.
// The search buffer and the look-ahead buffer form one contiguous array, so a
// match is allowed to run from the search buffer into the look-ahead.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_valid/in_ready        input character handshake
//   in_data, in_last         character and end-of-stream marker
//   out_valid/out_ready      token handshake
//   out_offset               SEARCH_LEN-1 minus the matched search index
//   out_match_len            match length, 0..LOOK_LEN-1
//   out_char_nxt, out_last   character after the match, final-token flag
//   finish                   level, stream fully encoded
//
// Build option: LZ77_END_CHAR_EN. When it is defined, an accepted FILL_CHAR
// also terminates the stream, for legacy '$'-terminated images.
//
// state | meaning
// FILL  | load look-ahead until full or last character seen
// SCAN  | evaluate one search index per cycle, keep the best match
// EMIT  | present the registered token until out_ready
// SHIFT | slide the window best_len+1 places, pulling input if any remains
// DONE  | stream finished, hold until reset
module lz77_stream_encoder #(
    parameter int              CHAR_W     = 8,
    parameter int              SEARCH_LEN = 9,
    parameter int              LOOK_LEN   = 8,
    parameter int              OFF_W      = $clog2(SEARCH_LEN),
    parameter int              LEN_W      = $clog2(LOOK_LEN),
    parameter logic [CHAR_W-1:0] FILL_CHAR = 8'h24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OFF_W-1:0]  out_offset,
    output logic [LEN_W-1:0]  out_match_len,
    output logic [CHAR_W-1:0] out_char_nxt,
    output logic              out_last,
    output logic              finish
);

    localparam int N     = SEARCH_LEN + LOOK_LEN;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(LOOK_LEN + 1);

    typedef enum logic [2:0] {FILL, SCAN, EMIT, SHIFT, DONE} state_t;

    state_t             state;
    logic [CHAR_W-1:0]  arr [N];
    logic [CNT_W-1:0]   look_cnt;
    logic               last_seen;
    logic [OFF_W-1:0]   scan_idx;
    logic [OFF_W-1:0]   best_off;
    logic [LEN_W-1:0]   best_len;
    logic [LEN_W:0]     shift_left;

    logic [LEN_W-1:0]   cand_len;
    logic [LEN_W-1:0]   nb_len;
    logic [OFF_W-1:0]   nb_off;
    logic               run;
    logic               accept;
    logic               last_beat;

    assign accept = in_valid && in_ready;

`ifdef LZ77_END_CHAR_EN
    assign last_beat = in_last || (in_data == FILL_CHAR);
`else
    assign last_beat = in_last;
`endif

    // Match length of the current candidate, capped at look_cnt-1 so that
    // a following character always exists. Strict '>' keeps the earliest
    // index (largest offset) on ties.
    always_comb begin
        cand_len = '0;
        run      = 1'b1;
        for (int k = 0; k < LOOK_LEN - 1; k++) begin
            if (run && (k < int'(look_cnt) - 1) &&
                (arr[IDX_W'(scan_idx) + IDX_W'(k)] == arr[IDX_W'(SEARCH_LEN) + IDX_W'(k)]))
                cand_len = cand_len + LEN_W'(1);
            else
                run = 1'b0;
        end
        nb_len = best_len;
        nb_off = best_off;
        if (cand_len > best_len) begin
            nb_len = cand_len;
            nb_off = OFF_W'(SEARCH_LEN - 1) - scan_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FILL;
            for (int j = 0; j < N; j++) arr[j] <= FILL_CHAR;
            look_cnt      <= '0;
            last_seen     <= 1'b0;
            scan_idx      <= '0;
            best_off      <= '0;
            best_len      <= '0;
            shift_left    <= '0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_offset    <= '0;
            out_match_len <= '0;
            out_char_nxt  <= '0;
            out_last      <= 1'b0;
            finish        <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        arr[IDX_W'(SEARCH_LEN) + IDX_W'(look_cnt)] <= in_data;
                        look_cnt <= look_cnt + CNT_W'(1);
                        if (last_beat) last_seen <= 1'b1;
                        if (last_beat || look_cnt == CNT_W'(LOOK_LEN - 1)) begin
                            in_ready <= 1'b0;
                            scan_idx <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    best_len <= nb_len;
                    best_off <= nb_off;
                    if (scan_idx == OFF_W'(SEARCH_LEN - 1)) begin
                        out_valid     <= 1'b1;
                        out_offset    <= nb_off;
                        out_match_len <= nb_len;
                        out_char_nxt  <= arr[IDX_W'(SEARCH_LEN) + IDX_W'(nb_len)];
                        out_last      <= last_seen && (int'(look_cnt) == int'(nb_len) + 1);
                        state         <= EMIT;
                    end else begin
                        scan_idx <= scan_idx + OFF_W'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid     <= 1'b0;
                        out_offset    <= '0;
                        out_match_len <= '0;
                        out_char_nxt  <= '0;
                        out_last      <= 1'b0;
                        if (out_last) begin
                            finish <= 1'b1;
                            state  <= DONE;
                        end else begin
                            shift_left <= {1'b0, best_len} + (LEN_W + 1)'(1);
                            in_ready   <= !last_seen;
                            state      <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // Once the last character is in, the tail drains without input.
                    if (last_seen || accept) begin
                        for (int j = 0; j < N - 1; j++) arr[j] <= arr[j+1];
                        arr[N-1] <= last_seen ? FILL_CHAR : in_data;
                        if (last_seen) begin
                            look_cnt <= look_cnt - CNT_W'(1);
                        end else if (last_beat) begin
                            last_seen <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                        shift_left <= shift_left - (LEN_W + 1)'(1);
                        if (shift_left == (LEN_W + 1)'(1)) begin
                            in_ready <= 1'b0;
                            scan_idx <= '0;
                            best_len <= '0;
                            best_off <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_stream_encoder.sv
module tb_lz77_stream_encoder;

    localparam int S = 9;
    localparam int L = 8;
    localparam logic [7:0] FILL = 8'h24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_offset;
    logic [2:0] out_match_len;
    logic [7:0] out_char_nxt;
    logic       out_last;
    logic       finish;

    lz77_stream_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_offset(out_offset), .out_match_len(out_match_len),
        .out_char_nxt(out_char_nxt), .out_last(out_last), .finish(finish)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] off;
        logic [2:0] len;
        logic [7:0] ch;
        logic       last;
    } tok_t;

    tok_t       exp_q[$];
    logic [7:0] stim[$];
    int errors = 0;
    int checks = 0;
    int rdy_pct = 100;
    int hold_cycles = 0;
    int hold_cnt = 0;
    int tok_cnt = 0;
    bit hs_flag = 0;
    bit done_flag = 0;
    bit burst_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain LZ77 over the whole stream, window prefilled with FILL.
    task automatic model(input int n);
        logic [7:0] ext[$];
        int p, avail, best, boff, l;
        tok_t t;
        ext.delete();
        for (int i = 0; i < S; i++) ext.push_back(FILL);
        for (int i = 0; i < n; i++) ext.push_back(stim[i]);
        p = 0;
        while (p < n) begin
            avail = (n - p < L) ? n - p : L;
            best = 0;
            boff = 0;
            for (int i = 0; i < S; i++) begin
                l = 0;
                while (l < avail - 1 && ext[p+i+l] == ext[S+p+l]) l++;
                if (l > best) begin
                    best = l;
                    boff = S - 1 - i;
                end
            end
            t.off  = 4'(boff);
            t.len  = 3'(best);
            t.ch   = stim[p+best];
            t.last = (n - p == best + 1);
            exp_q.push_back(t);
            p += best + 1;
        end
    endtask

    task automatic load(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        tok_t e, cur, held;
        bit prev_hold, prev_rdy, prev_acc, chk_fin;
        prev_hold = 0; prev_rdy = 0; prev_acc = 0; chk_fin = 0; held = '0;
        forever begin
            @(negedge clk);
            cur = {out_offset, out_match_len, out_char_nxt, out_last};
            if (reset) begin
                prev_hold = 0; prev_rdy = 0; prev_acc = 0; chk_fin = 0;
            end else begin
                if (chk_fin) begin
                    chk("finish_after_last", 32'(finish), 32'd1);
                    chk_fin = 0;
                end
                if (prev_hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_fields", 32'(cur), 32'(held));
                end
                if (prev_rdy && !prev_acc) chk("in_ready_stall", 32'(in_ready), 32'd1);
                if (out_valid) chk("in_ready_in_emit", 32'(in_ready), 32'd0);
                if (out_valid && out_ready) begin
                    tok_cnt++;
                    hs_flag = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_token: got %0h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tok_offset", 32'(out_offset), 32'(e.off));
                        chk("tok_len", 32'(out_match_len), 32'(e.len));
                        chk("tok_char", 32'(out_char_nxt), 32'(e.ch));
                        chk("tok_last", 32'(out_last), 32'(e.last));
                        if (e.last) begin
                            done_flag = 1;
                            chk_fin = 1;
                        end
                    end
                end
                prev_hold = out_valid && !out_ready;
                held      = cur;
                prev_rdy  = in_ready;
                prev_acc  = in_valid && in_ready;
            end
        end
    end

    // Downstream ready: either a fixed hold per token or random.
    initial forever begin
        @(posedge clk);
        #1;
        if (hold_cycles > 0) begin
            if (out_valid && hold_cnt < hold_cycles) begin
                out_ready = 1'b0;
                hold_cnt++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) hold_cnt = 0;
            end
        end else begin
            out_ready = ($urandom_range(0, 99) < 32'(rdy_pct));
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_offset", 32'(out_offset), 32'd0);
        chk("rst_len", 32'(out_match_len), 32'd0);
        chk("rst_char", 32'(out_char_nxt), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        hs_flag = 0;
        done_flag = 0;
        hold_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input int from, input int to, input bit with_last, input int stall_pct);
        int idx, guard, drop;
        idx = from; guard = 0; drop = 0;
        while (idx <= to) begin
            @(posedge clk);
            #1;
            if (hs_flag) begin
                hs_flag = 0;
                if (burst_mode) drop = 4;
            end
            if (drop > 0) begin
                in_valid = 1'b0;
                drop--;
            end else if ($urandom_range(0, 99) < 32'(stall_pct)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = stim[idx];
                in_last  = with_last && (idx == to);
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            guard++;
            if (guard > 20000) begin
                chk("send_timeout", 32'(idx), 32'(to + 1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!done_flag && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("done_in_budget", 32'(done_flag), 32'd1);
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_stream(input int stall_pct, input int rdy, input int holdc, input bit burst);
        do_reset();
        rdy_pct = rdy;
        hold_cycles = holdc;
        burst_mode = burst;
        model(stim.size());
        send(0, stim.size() - 1, 1'b1, stall_pct);
        wait_done(5000);
        hold_cycles = 0;
        burst_mode = 0;
        rdy_pct = 100;
    endtask

    initial begin
        int n;
        int tok0;
        int lens[5] = '{1, 2, 8, 9, 17};

        load("aaaa");
        run_stream(0, 100, 0, 0);

        load("ababab");
        run_stream(0, 100, 0, 0);

        load("aaaa");
        run_stream(0, 100, 5, 0);

        load("abababababababababab");
        run_stream(0, 100, 0, 1);

        // Reset in SCAN of the second token.
        do_reset();
        load("abcdefghabcd");
        model(stim.size());
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        send(0, 8, 1'b0, 0);
        chk("first_token_seen", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        load("aaaa");
        run_stream(0, 100, 0, 0);

`ifdef LZ77_END_CHAR_EN
        do_reset();
        load("a$");
        model(2);
        send(0, 1, 1'b0, 0);
        wait_done(2000);
`else
        do_reset();
        load("a$b");
        model(3);
        tok0 = tok_cnt;
        send(0, 1, 1'b0, 0);
        repeat (40) @(negedge clk);
        chk("no_token_before_last", 32'(tok_cnt - tok0), 32'd0);
        send(2, 2, 1'b1, 0);
        wait_done(2000);
`endif

        for (int t = 0; t < 5; t++) begin
            stim.delete();
            for (int i = 0; i < lens[t]; i++) stim.push_back(8'h61 + 8'($urandom_range(0, 2)));
            run_stream(25, 60, 0, 0);
        end

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 40);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(8'h61 + 8'($urandom_range(0, 2)));
            run_stream(30, 50, 0, (t % 2) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
